// File: rtl/mcu_seq.sv
// Phase sequencer ahead of the memory control unit: drives phase code {o_eop,o_sop}
// and column-block strobes. Optional stall watchdog enabled by MCU_SEQ_TIMEOUT_EN.
module mcu_seq #(
  parameter int IMG_H       = 8,
  parameter int BLK_W       = 10,
  parameter int PROC_CYCLES = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic [BLK_W-1:0] i_blocks,
  output logic             o_cmd_ready,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_chblk,
  output logic             o_done,
  output logic             o_err
);
  // State encoding doubles as the phase code {o_eop, o_sop}.
  localparam logic [1:0] S_IDLE = 2'b11;
  localparam logic [1:0] S_LOAD = 2'b00;
  localparam logic [1:0] S_PROC = 2'b01;
  localparam logic [1:0] S_OUT  = 2'b10;

  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;

  logic [1:0]       state;
  logic [RW-1:0]    row;
  logic [BLK_W-1:0] blk, blocks;
  logic [PW-1:0]    pcnt;
  logic             xfer, row_last, blk_last;

  assign o_sop        = state[0];
  assign o_eop        = state[1];
  assign o_cmd_ready  = (state == S_IDLE);
  assign o_data_ready = (state == S_LOAD);
  assign o_out_valid  = (state == S_OUT);

  assign xfer     = (state == S_LOAD && i_data_valid) || (state == S_OUT && i_out_ready);
  assign row_last = (row == RW'(IMG_H - 1));
  assign blk_last = (blk == blocks - BLK_W'(1));

`ifdef MCU_SEQ_TIMEOUT_EN
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [SW-1:0] stall;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      row     <= '0;
      blk     <= '0;
      blocks  <= '0;
      pcnt    <= '0;
      o_chblk <= 1'b0;
      o_done  <= 1'b0;
`ifdef MCU_SEQ_TIMEOUT_EN
      stall   <= '0;
      o_err   <= 1'b0;
`endif
    end else begin
      o_chblk <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        S_IDLE: if (i_cmd_valid) begin
`ifdef MCU_SEQ_TIMEOUT_EN
          o_err <= 1'b0;
          stall <= '0;
`endif
          case (i_cmd)
            2'b00, 2'b10: begin
              if (i_blocks != '0) begin
                blocks <= i_blocks;
                state  <= (i_cmd == 2'b00) ? S_LOAD : S_OUT;
                row    <= '0;
                blk    <= '0;
              end else begin
                o_done <= 1'b1;
              end
            end
            2'b01: begin
              state <= S_PROC;
              pcnt  <= '0;
            end
            default: ;
          endcase
        end
        S_LOAD, S_OUT: begin
          if (xfer) begin
`ifdef MCU_SEQ_TIMEOUT_EN
            stall <= '0;
`endif
            if (row_last) begin
              row <= '0;
              if (blk_last) begin
                blk    <= '0;
                state  <= S_IDLE;
                o_done <= 1'b1;
              end else begin
                blk     <= blk + BLK_W'(1);
                o_chblk <= 1'b1;
              end
            end else begin
              row <= row + RW'(1);
            end
          end
`ifdef MCU_SEQ_TIMEOUT_EN
          // This cycle's stall brings the count to TIMEOUT-1: abort without o_done.
          else if (stall == SW'(TIMEOUT - 2)) begin
            stall <= '0;
            row   <= '0;
            blk   <= '0;
            state <= S_IDLE;
            o_err <= 1'b1;
          end else begin
            stall <= stall + SW'(1);
          end
`endif
        end
        S_PROC: begin
          if (pcnt == PW'(PROC_CYCLES - 1)) begin
            pcnt   <= '0;
            state  <= S_IDLE;
            o_done <= 1'b1;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcu_seq.sv
// Self-checking bench for mcu_seq: command table, directed phase sequences and
// randomized traffic compared every cycle against a word-count reference model.
module tb_mcu_seq;
  localparam int IMG_H = 4, BLK_W = 10, PROC_CYCLES = 6, TIMEOUT = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic i_cmd_valid = 1'b0, i_data_valid = 1'b0, i_out_ready = 1'b0;
  logic [1:0] i_cmd = 2'b11;
  logic [BLK_W-1:0] i_blocks = '0;
  logic o_cmd_ready, o_data_ready, o_out_valid, o_sop, o_eop, o_chblk, o_done, o_err;

  mcu_seq #(.IMG_H(IMG_H), .BLK_W(BLK_W), .PROC_CYCLES(PROC_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .i_blocks(i_blocks),
    .o_cmd_ready(o_cmd_ready), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_sop(o_sop), .o_eop(o_eop),
    .o_chblk(o_chblk), .o_done(o_done), .o_err(o_err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: phase name plus words/cycles still owed.
  typedef enum int {P_IDLE, P_LOAD, P_PROC, P_OUT} phase_t;
  phase_t m_phase = P_IDLE;
  int m_left = 0, m_pleft = 0, m_stall = 0;
  bit m_done = 0, m_chblk = 0, m_err = 0;

  function automatic logic [7:0] dut_vec();
    return {o_eop, o_sop, o_cmd_ready, o_data_ready, o_out_valid, o_chblk, o_done, o_err};
  endfunction

  function automatic logic [7:0] model_vec();
    logic [1:0] code;
    case (m_phase)
      P_IDLE:  code = 2'b11;
      P_LOAD:  code = 2'b00;
      P_PROC:  code = 2'b01;
      default: code = 2'b10;
    endcase
    return {code, m_phase == P_IDLE, m_phase == P_LOAD, m_phase == P_OUT, m_chblk, m_done, m_err};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b ({eop,sop,crdy,drdy,ovld,chblk,done,err}) t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit cv, input logic [1:0] cmd, input int blk, input bit dv, input bit ordy);
    bit x;
    m_done  = 0;
    m_chblk = 0;
    case (m_phase)
      P_IDLE: if (cv) begin
`ifdef MCU_SEQ_TIMEOUT_EN
        m_err = 0;
`endif
        if (cmd == 2'b00 || cmd == 2'b10) begin
          if (blk == 0) m_done = 1;
          else begin
            m_phase = (cmd == 2'b00) ? P_LOAD : P_OUT;
            m_left  = blk * IMG_H;
            m_stall = 0;
          end
        end else if (cmd == 2'b01) begin
          m_phase = P_PROC;
          m_pleft = PROC_CYCLES;
        end
      end
      P_LOAD, P_OUT: begin
        x = (m_phase == P_LOAD) ? dv : ordy;
        if (x) begin
          m_stall = 0;
          m_left--;
          if (m_left == 0) begin m_phase = P_IDLE; m_done = 1; end
          else if (m_left % IMG_H == 0) m_chblk = 1;
        end
`ifdef MCU_SEQ_TIMEOUT_EN
        else begin
          m_stall++;
          if (m_stall == TIMEOUT - 1) begin m_phase = P_IDLE; m_err = 1; end
        end
`endif
      end
      default: begin
        m_pleft--;
        if (m_pleft == 0) begin m_phase = P_IDLE; m_done = 1; end
      end
    endcase
  endtask

  // One clock: compare current outputs, apply inputs, advance model, land on next negedge.
  task automatic cyc(input bit cv, input logic [1:0] cmd, input int blk, input bit dv, input bit ordy);
    check("model", dut_vec(), model_vec());
    i_cmd_valid  = cv;
    i_cmd        = cmd;
    i_blocks     = BLK_W'(blk);
    i_data_valid = dv;
    i_out_ready  = ordy;
    model_step(cv, cmd, blk, dv, ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_cmd_valid = 0; i_data_valid = 0; i_out_ready = 0;
    #2 rst = 1'b0;
    #1 check("async_reset", dut_vec(), 8'b1110_0000);
    m_phase = P_IDLE; m_done = 0; m_chblk = 0; m_err = 0; m_stall = 0;
    @(negedge clk);
    check("in_reset", dut_vec(), 8'b1110_0000);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0] cmd;
    int         blk;
    logic [1:0] code;
    logic       done;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int xfers;
    tbl[0] = '{2'b00, 0, 2'b11, 1'b1};
    tbl[1] = '{2'b10, 0, 2'b11, 1'b1};
    tbl[2] = '{2'b11, 7, 2'b11, 1'b0};
    tbl[3] = '{2'b01, 0, 2'b01, 1'b0};
    tbl[4] = '{2'b00, 3, 2'b00, 1'b0};
    tbl[5] = '{2'b10, 2, 2'b10, 1'b0};
    tbl[6] = '{2'b11, 0, 2'b11, 1'b0};

    @(negedge clk);
    do_reset();

    // Command acceptance table: code and o_done on the cycle after accept.
    foreach (tbl[i]) begin
      cyc(1, tbl[i].cmd, tbl[i].blk, 0, 0);
      check1($sformatf("tbl%0d_code", i), o_eop, tbl[i].code[1]);
      check1($sformatf("tbl%0d_sop", i), o_sop, tbl[i].code[0]);
      check1($sformatf("tbl%0d_done", i), o_done, tbl[i].done);
      cyc(0, 2'b11, 0, 0, 0);
      check1($sformatf("tbl%0d_done_once", i), o_done, 1'b0);
      do_reset();
    end

    // LOAD 3 blocks, 12 back-to-back words.
    cyc(1, 2'b00, 3, 0, 0);
    check("load_start", dut_vec(), 8'b0001_0000);
    for (int w = 1; w <= 12; w++) begin
      cyc(0, 2'b11, 0, 1, 0);
      check1($sformatf("load_chblk_w%0d", w), o_chblk, (w == 4 || w == 8));
      check1($sformatf("load_done_w%0d", w), o_done, (w == 12));
    end
    check("load_end", dut_vec(), 8'b1110_0010);

    // OUT 2 blocks, ready toggling 1,0,1,0.
    cyc(1, 2'b10, 2, 0, 0);
    xfers = 0;
    for (int i = 0; i < 15; i++) begin
      bit r;
      r = (i % 2 == 0);
      cyc(0, 2'b11, 0, 1, r);
      if (r) xfers++;
      check1($sformatf("out_chblk_c%0d", i), o_chblk, (r && xfers == 4));
      check1($sformatf("out_done_c%0d", i), o_done, (r && xfers == 8));
    end

    // PROC held exactly PROC_CYCLES cycles; offered words refused.
    cyc(1, 2'b01, 0, 0, 0);
    for (int k = 0; k < PROC_CYCLES; k++) begin
      check($sformatf("proc_c%0d", k), dut_vec(), 8'b0100_0000);
      cyc(0, 2'b11, 0, 1, 1);
    end
    check("proc_end", dut_vec(), 8'b1110_0010);

    // Reset mid-LOAD after 3 words, then a fresh 1-block LOAD needs all IMG_H words.
    cyc(1, 2'b00, 2, 0, 0);
    for (int w = 0; w < 3; w++) cyc(0, 2'b11, 0, 1, 0);
    do_reset();
    cyc(1, 2'b00, 1, 0, 0);
    for (int w = 1; w <= IMG_H; w++) begin
      cyc(0, 2'b11, 0, 1, 0);
      check1($sformatf("reload_done_w%0d", w), o_done, (w == IMG_H));
    end

`ifdef MCU_SEQ_TIMEOUT_EN
    cyc(1, 2'b00, 1, 0, 0);
    cyc(0, 2'b11, 0, 1, 0);
    cyc(0, 2'b11, 0, 1, 0);
    for (int n = 1; n < TIMEOUT; n++) begin
      check1($sformatf("wd_hold_%0d", n), o_data_ready, 1'b1);
      cyc(0, 2'b11, 0, 0, 0);
    end
    check("wd_abort", dut_vec(), 8'b1110_0001);
    cyc(1, 2'b11, 0, 0, 0);
    check1("wd_err_clear", o_err, 1'b0);
`endif

    // Randomized traffic with busy-time command noise.
    for (int t = 0; t < 60; t++) begin
      logic [1:0] cmd;
      int budget;
      cmd = 2'($urandom_range(0, 3));
      cyc(1, cmd, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      budget = 0;
      while (m_phase != P_IDLE && budget < 200) begin
        cyc($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 3),
            $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
        budget++;
      end
      check1("rand_budget", budget < 200, 1'b1);
      if ($urandom_range(0, 2) == 0) cyc(0, 2'b11, 0, 1, 1);
    end
    cyc(0, 2'b11, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
